// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed 7-segment scheduler:
// FSM state, active-low digit selects and active-low segment patterns {g,f,e,d,c,b,a}.
package seg_pkg;

  typedef enum logic {
    ST_BASE = 1'b0,
    ST_MSG  = 1'b1
  } state_e;

  localparam logic [3:0] DIG_0   = 4'b1110;  // rightmost digit, nibble [3:0]
  localparam logic [3:0] DIG_1   = 4'b1101;
  localparam logic [3:0] DIG_2   = 4'b1011;
  localparam logic [3:0] DIG_3   = 4'b0111;
  localparam logic [3:0] DIG_OFF = 4'b1111;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Anything that is not a valid scan position restarts at the rightmost digit.
  function automatic logic [3:0] next_digit(input logic [3:0] cur);
    case (cur)
      DIG_0:   return DIG_1;
      DIG_1:   return DIG_2;
      DIG_2:   return DIG_3;
      default: return DIG_0;
    endcase
  endfunction

endpackage

// File: rtl/seg_decode.sv
// Combinational nibble to active-low segment decoder: 0-9 digits, 10 dash, 11-15 blank.
module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (nibble_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      4'd10:   seg_o = SEG_DASH;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scheduler.sv
// 4-digit 7-segment scan scheduler with timed, retriggerable message overlay.
// Define SEG_SCHEDULER_BLINK_EN to honour blink_en (message blanked in the off phase).
module seg_scheduler
  import seg_pkg::*;
#(
  parameter int SCAN_DIV  = 65536,
  parameter int BLINK_DIV = 8388608,
  parameter int MSG_HOLD  = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] base_nums,
  input  logic        msg_req,
  input  logic [15:0] msg_nums,
  input  logic        blink_en,
  output logic        msg_ack,
  output logic        msg_busy,
  output logic [3:0]  digit,
  output logic [6:0]  display
);

  localparam int SCAN_W  = $clog2(SCAN_DIV);
  localparam int BLINK_W = $clog2(BLINK_DIV);
  localparam int HOLD_W  = $clog2(MSG_HOLD + 1);

  state_e             state_q, state_d;
  logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               phase_q, phase_d;
  logic [15:0]        msg_q, msg_d;
  logic [3:0]         sel_q, sel_d;
  logic [3:0]         digit_q, digit_d;
  logic [6:0]         display_q, display_d;
  logic               ack_q;

  logic               scan_tick, blink_tick, blank;
  logic [3:0]         sel_next, nibble;
  logic [15:0]        src;
  logic [6:0]         seg_w;

  assign scan_tick  = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));
  assign blink_tick = (blink_cnt_q == BLINK_W'(BLINK_DIV - 1));

`ifdef SEG_SCHEDULER_BLINK_EN
  assign blank = (state_q == ST_MSG) && blink_en && !phase_q;
`else
  logic unused_blink_en;
  assign unused_blink_en = blink_en;
  assign blank = 1'b0;
`endif

  // Control: request acceptance (also retrigger) takes priority over hold expiry.
  always_comb begin
    state_d     = state_q;
    scan_cnt_d  = scan_tick ? '0 : scan_cnt_q + SCAN_W'(1);
    blink_cnt_d = blink_tick ? '0 : blink_cnt_q + BLINK_W'(1);
    phase_d     = blink_tick ? ~phase_q : phase_q;
    hold_d      = hold_q;
    msg_d       = msg_q;
    if (msg_req) begin
      state_d     = ST_MSG;
      msg_d       = msg_nums;
      hold_d      = '0;
      phase_d     = 1'b1;
      blink_cnt_d = '0;
    end else if (state_q == ST_MSG && blink_tick) begin
      if (hold_q == HOLD_W'(MSG_HOLD - 1)) begin
        state_d = ST_BASE;
        hold_d  = '0;
        phase_d = 1'b1;
      end else begin
        hold_d = hold_q + HOLD_W'(1);
      end
    end
  end

  // Display: position, anode and segments all move together on the scan tick.
  assign sel_next = next_digit(sel_q);
  assign src      = (state_q == ST_MSG) ? msg_q : base_nums;

  always_comb begin
    case (sel_next)
      DIG_1:   nibble = src[7:4];
      DIG_2:   nibble = src[11:8];
      DIG_3:   nibble = src[15:12];
      default: nibble = src[3:0];
    endcase
  end

  seg_decode u_decode (
    .nibble_i (nibble),
    .seg_o    (seg_w)
  );

  always_comb begin
    sel_d     = sel_q;
    digit_d   = digit_q;
    display_d = display_q;
    if (scan_tick) begin
      sel_d     = sel_next;
      digit_d   = blank ? DIG_OFF : sel_next;
      display_d = blank ? SEG_BLANK : seg_w;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_BASE;
      scan_cnt_q  <= '0;
      blink_cnt_q <= '0;
      hold_q      <= '0;
      phase_q     <= 1'b1;
      msg_q       <= '0;
      sel_q       <= DIG_OFF;
      digit_q     <= DIG_OFF;
      display_q   <= SEG_BLANK;
      ack_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      scan_cnt_q  <= scan_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      hold_q      <= hold_d;
      phase_q     <= phase_d;
      msg_q       <= msg_d;
      sel_q       <= sel_d;
      digit_q     <= digit_d;
      display_q   <= display_d;
      ack_q       <= msg_req;
    end
  end

  assign msg_ack  = ack_q;
  assign msg_busy = (state_q == ST_MSG);
  assign digit    = digit_q;
  assign display  = display_q;

endmodule

// File: tb/tb_seg_scheduler.sv
// Directed bench for seg_scheduler with SCAN_DIV=4, BLINK_DIV=8, MSG_HOLD=3.
module tb_seg_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] base_nums;
  logic        msg_req;
  logic [15:0] msg_nums;
  logic        blink_en;
  logic        msg_ack;
  logic        msg_busy;
  logic [3:0]  digit;
  logic [6:0]  display;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  seg_scheduler #(.SCAN_DIV(4), .BLINK_DIV(8), .MSG_HOLD(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .base_nums (base_nums),
    .msg_req   (msg_req),
    .msg_nums  (msg_nums),
    .blink_en  (blink_en),
    .msg_ack   (msg_ack),
    .msg_busy  (msg_busy),
    .digit     (digit),
    .display   (display)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_disp(input string tag, input logic [3:0] d, input logic [6:0] s);
    chk({tag, ".digit"}, {12'h0, digit}, {12'h0, d});
    chk({tag, ".display"}, {9'h0, display}, {9'h0, s});
  endtask

  // Advance to the given cycle count (posedges since reset release), sample 1 ns later.
  task automatic go_to(input int t);
    while (cyc < t) begin
      @(posedge clk);
      cyc++;
    end
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    base_nums = 16'h1234;
    msg_req   = 1'b0;
    msg_nums  = 16'h0000;
    blink_en  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_disp("reset", 4'b1111, 7'b1111111);
    chk("reset.busy", {15'h0, msg_busy}, 16'h0);
    chk("reset.ack", {15'h0, msg_ack}, 16'h0);
    rst_n = 1'b1;
    cyc   = 0;

    // Base scan of 1234: rightmost first, one digit every 4 cycles
    go_to(3);  chk_disp("pre_tick", 4'b1111, 7'b1111111);
    go_to(4);  chk_disp("scan0", 4'b1110, 7'b0011001);
    go_to(8);  chk_disp("scan1", 4'b1101, 7'b0110000);
    go_to(12); chk_disp("scan2", 4'b1011, 7'b0100100);
    go_to(16); chk_disp("scan3", 4'b0111, 7'b1111001);
    go_to(20); chk_disp("scan_wrap", 4'b1110, 7'b0011001);

    // Message AAAA, blink off: dashes for 24 cycles
    msg_req = 1'b1; msg_nums = 16'hAAAA;
    go_to(21); msg_req = 1'b0;
    chk("msg1.ack", {15'h0, msg_ack}, 16'h1);
    chk("msg1.busy", {15'h0, msg_busy}, 16'h1);
    go_to(22); chk("msg1.ack_pulse", {15'h0, msg_ack}, 16'h0);
    go_to(24); chk_disp("msg1.t24", 4'b1101, 7'b0111111);
    go_to(32); chk_disp("msg1.t32", 4'b0111, 7'b0111111);
    go_to(36); chk_disp("msg1.t36", 4'b1110, 7'b0111111);
    go_to(44); chk_disp("msg1.t44", 4'b1011, 7'b0111111);
    chk("msg1.busy_end", {15'h0, msg_busy}, 16'h1);
    go_to(45); chk("msg1.expired", {15'h0, msg_busy}, 16'h0);
    go_to(48); chk_disp("base_back", 4'b0111, 7'b1111001);

    // Message with blink enabled: off phase covers the ticks at 60 and 64
    msg_req = 1'b1; blink_en = 1'b1;
    go_to(49); msg_req = 1'b0;
    chk("msg2.ack", {15'h0, msg_ack}, 16'h1);
    go_to(52); chk_disp("blink.t52", 4'b1110, 7'b0111111);
    go_to(56); chk_disp("blink.t56", 4'b1101, 7'b0111111);
`ifdef SEG_SCHEDULER_BLINK_EN
    go_to(60); chk_disp("blink.t60", 4'b1111, 7'b1111111);
    go_to(64); chk_disp("blink.t64", 4'b1111, 7'b1111111);
`else
    go_to(60); chk_disp("blink.t60", 4'b1011, 7'b0111111);
    go_to(64); chk_disp("blink.t64", 4'b0111, 7'b0111111);
`endif
    go_to(68); chk_disp("blink.t68", 4'b1110, 7'b0111111);
    go_to(72); chk_disp("blink.t72", 4'b1101, 7'b0111111);
    chk("blink.busy72", {15'h0, msg_busy}, 16'h1);
    go_to(73); chk("blink.busy73", {15'h0, msg_busy}, 16'h0);
    go_to(76); chk_disp("blink.base", 4'b1011, 7'b0100100);

    // Retrigger with 5555 at cycle 20 of an AAAA message
    blink_en = 1'b0; msg_req = 1'b1; msg_nums = 16'hAAAA;
    go_to(77); msg_req = 1'b0;
    chk("msg3.ack", {15'h0, msg_ack}, 16'h1);
    go_to(96); chk_disp("msg3.t96", 4'b0111, 7'b0111111);
    msg_req = 1'b1; msg_nums = 16'h5555;
    go_to(97); msg_req = 1'b0;
    chk("retrig.ack", {15'h0, msg_ack}, 16'h1);
    chk("retrig.busy", {15'h0, msg_busy}, 16'h1);
    go_to(100); chk_disp("retrig.t100", 4'b1110, 7'b0010010);
    go_to(101); chk("retrig.busy101", {15'h0, msg_busy}, 16'h1);
    go_to(104); chk_disp("retrig.t104", 4'b1101, 7'b0010010);
    go_to(120); chk_disp("retrig.t120", 4'b1101, 7'b0010010);
    chk("retrig.busy120", {15'h0, msg_busy}, 16'h1);
    go_to(121); chk("retrig.busy121", {15'h0, msg_busy}, 16'h0);
    go_to(124); chk_disp("retrig.base", 4'b1011, 7'b0100100);

    // Blank nibbles B..F
    base_nums = 16'hBCDF;
    go_to(128); chk_disp("blank.t128", 4'b0111, 7'b1111111);
    go_to(132); chk_disp("blank.t132", 4'b1110, 7'b1111111);

    // Reset in the middle of a message
    msg_req = 1'b1; msg_nums = 16'hAAAA;
    go_to(133); msg_req = 1'b0;
    chk("msg4.busy", {15'h0, msg_busy}, 16'h1);
    go_to(136); chk_disp("msg4.t136", 4'b1101, 7'b0111111);
    #3 rst_n = 1'b0;
    #1;
    chk_disp("abort", 4'b1111, 7'b1111111);
    chk("abort.busy", {15'h0, msg_busy}, 16'h0);
    chk("abort.ack", {15'h0, msg_ack}, 16'h0);
    @(posedge clk);
    #1;
    base_nums = 16'h1234;
    rst_n = 1'b1;
    cyc   = 0;
    go_to(3);
    chk_disp("rel.pre_tick", 4'b1111, 7'b1111111);
    chk("rel.busy", {15'h0, msg_busy}, 16'h0);
    chk("rel.ack", {15'h0, msg_ack}, 16'h0);
    go_to(4);
    chk_disp("rel.scan0", 4'b1110, 7'b0011001);
    chk("rel.busy4", {15'h0, msg_busy}, 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
